// File: rtl/fetch_seq_pkg.sv
// Shared encodings for the fetch sequencer: next-address operations and FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fetch_seq_pkg;

    localparam int PC_OP_W = 3;

    // Next-address operation; unlisted codes behave as HOLD.
    typedef enum logic [PC_OP_W-1:0] {
        OP_HOLD = 3'b000,
        OP_INC  = 3'b001,
        OP_JUMP = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100,
        OP_HALT = 3'b101
    } pc_op_e;

    // Sequencer state: one BOOT cycle after reset, then RUN until a HALT op.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_ret_stack.sv
// LIFO of return addresses used by CALL/RET.
// Latency: push/pop take effect on the next clock edge; top/full/empty reflect current contents.
// Backpressure: none; push when full and pop when empty are ignored, and the caller flags them.
module fetch_ret_stack #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // count is the index of the next free slot; the top entry sits just below it.
    assign wr_idx = IDX_W'(count);
    assign rd_idx = IDX_W'(count - CNT_W'(1));
    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign top    = mem[rd_idx];

    // Entry storage; contents above count are don't-care, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Occupancy; reset empties the stack so no partial update survives.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch address sequencer (BOOT/RUN/HALT) with optional return stack (FETCH_SEQ_STACK_EN).
// Latency: addr updates one edge after pc_op; instr_valid marks memory data one cycle after a RUN fetch.
// Backpressure: stall freezes addr, stack and flags and suppresses instr_valid on the following cycle.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int INSTR_W     = 9,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic               clk,
    input  logic               res,
    input  logic [PC_OP_W-1:0] pc_op,
    input  logic [ADDR_W-1:0]  target,
    input  logic               stall,
    output logic [ADDR_W-1:0]  addr,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               halted,
    output logic               stack_ovf,
    output logic               stack_unf
);

    localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RESET_ADDR);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] addr_inc;

    // Wraps modulo 2^ADDR_W without any flag.
    assign addr_inc  = addr + ADDR_W'(1);
    assign instr_out = instr_in;
    assign halted    = (state == ST_HALT);

`ifdef FETCH_SEQ_STACK_EN
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              unf_set;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] stk_top;

    fetch_ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .res       (res),
        .push      (push),
        .pop       (pop),
        .push_data (addr_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );
`endif

    // Next state, next address and stack requests; only RUN without stall changes anything.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
`ifdef FETCH_SEQ_STACK_EN
        push      = 1'b0;
        pop       = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
`endif
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (!stall) begin
                    case (pc_op)
                        OP_INC:  addr_nxt = addr_inc;
                        OP_JUMP: addr_nxt = target;
                        OP_CALL: begin
                            // A full stack still takes the jump; only the return address is lost.
                            addr_nxt = target;
`ifdef FETCH_SEQ_STACK_EN
                            if (stk_full) begin
                                ovf_set = 1'b1;
                            end else begin
                                push = 1'b1;
                            end
`endif
                        end
                        OP_RET: begin
`ifdef FETCH_SEQ_STACK_EN
                            // Returning with nothing to return to degrades to a sequential fetch.
                            if (stk_empty) begin
                                addr_nxt = addr_inc;
                                unf_set  = 1'b1;
                            end else begin
                                addr_nxt = stk_top;
                                pop      = 1'b1;
                            end
`else
                            addr_nxt = addr_inc;
`endif
                        end
                        OP_HALT: state_nxt = ST_HALT;
                        default: addr_nxt = addr;
                    endcase
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_BOOT;
        endcase
    end

    // State register; HALT is only left through reset.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch address and valid: memory data is fresh one cycle after an unstalled RUN cycle.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            addr        <= RST_ADDR;
            instr_valid <= 1'b0;
        end else begin
            addr        <= addr_nxt;
            instr_valid <= (state == ST_RUN) && !stall;
        end
    end

`ifdef FETCH_SEQ_STACK_EN
    // Sticky stack error flags, cleared only by reset.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            stack_ovf <= stack_ovf | ovf_set;
            stack_unf <= stack_unf | unf_set;
        end
    end
`else
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; expectations adapt to FETCH_SEQ_STACK_EN.
// Latency: inputs applied after a rising edge, outputs sampled 1 ns after the next one.
// Backpressure: stall exercised directly.
module tb_fetch_sequencer;
    import fetch_seq_pkg::*;

`ifdef FETCH_SEQ_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         res;
    logic [2:0]   pc_op;
    logic [5:0]   target;
    logic         stall;
    logic [5:0]   addr;
    logic [8:0]   instr_in;
    logic [8:0]   instr_out;
    logic         instr_valid;
    logic         halted;
    logic         stack_ovf;
    logic         stack_unf;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    fetch_sequencer #(
        .ADDR_W      (6),
        .INSTR_W     (9),
        .STACK_DEPTH (4),
        .RESET_ADDR  (0)
    ) dut (
        .clk         (clk),
        .res         (res),
        .pc_op       (pc_op),
        .target      (target),
        .stall       (stall),
        .addr        (addr),
        .instr_in    (instr_in),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .halted      (halted),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] o, input logic [5:0] t);
        pc_op  = o;
        target = t;
        tick();
    endtask

    // Pulse reset, release away from the edge, and step through the BOOT cycle.
    task automatic do_reset();
        res    = 1'b0;
        pc_op  = OP_HOLD;
        stall  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        res = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (addr !== 6'd0) $display("FAIL rst_addr got=%0d exp=0", addr); else pass_cnt++;
        chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", instr_valid); else pass_cnt++;
        chk_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted got=%b exp=0", halted); else pass_cnt++;
        chk_cnt++; if (stack_ovf !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", stack_ovf); else pass_cnt++;
        chk_cnt++; if (stack_unf !== 1'b0) $display("FAIL rst_unf got=%b exp=0", stack_unf); else pass_cnt++;
    endtask

    task automatic test_boot_inc();
        @(negedge clk);
        res = 1'b1;
        #1;
        chk_cnt++; if (addr !== 6'd0 || instr_valid !== 1'b0) $display("FAIL boot_c0 addr=%0d valid=%b exp 0/0", addr, instr_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (addr !== 6'd0 || instr_valid !== 1'b0) $display("FAIL boot_c1 addr=%0d valid=%b exp 0/0", addr, instr_valid); else pass_cnt++;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_cnt++; if (addr !== 6'(i) || instr_valid !== 1'b1) $display("FAIL boot_inc%0d addr=%0d valid=%b exp %0d/1", i, addr, instr_valid, i); else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        op(OP_JUMP, 6'd63);
        chk_cnt++; if (addr !== 6'd63) $display("FAIL wrap_jump got=%0d exp=63", addr); else pass_cnt++;
        op(OP_INC, 6'd0);
        chk_cnt++; if (addr !== 6'd0) $display("FAIL wrap_inc got=%0d exp=0", addr); else pass_cnt++;
        chk_cnt++; if (stack_ovf !== 1'b0 || stack_unf !== 1'b0) $display("FAIL wrap_flags ovf=%b unf=%b exp 0/0", stack_ovf, stack_unf); else pass_cnt++;
    endtask

    task automatic test_passthrough();
        instr_in = 9'h155;
        #1;
        chk_cnt++; if (instr_out !== 9'h155) $display("FAIL pass_a got=%h exp=155", instr_out); else pass_cnt++;
        instr_in = 9'h0AA;
        #1;
        chk_cnt++; if (instr_out !== 9'h0AA) $display("FAIL pass_b got=%h exp=0aa", instr_out); else pass_cnt++;
    endtask

    task automatic test_call_ret();
        logic [5:0] exp;
        do_reset();
        op(OP_JUMP, 6'd5);
        op(OP_CALL, 6'd20);
        chk_cnt++; if (addr !== 6'd20) $display("FAIL call_addr got=%0d exp=20", addr); else pass_cnt++;
        op(OP_INC, 6'd0);
        op(OP_RET, 6'd0);
        exp = STK ? 6'd6 : 6'd22;
        chk_cnt++; if (addr !== exp) $display("FAIL ret_addr got=%0d exp=%0d", addr, exp); else pass_cnt++;
        chk_cnt++; if (stack_unf !== 1'b0) $display("FAIL ret_unf got=%b exp=0", stack_unf); else pass_cnt++;
        // CALL from the last address pushes a wrapped return address of 0.
        op(OP_JUMP, 6'd63);
        op(OP_CALL, 6'd7);
        chk_cnt++; if (addr !== 6'd7) $display("FAIL callwrap_addr got=%0d exp=7", addr); else pass_cnt++;
        op(OP_RET, 6'd0);
        exp = STK ? 6'd0 : 6'd8;
        chk_cnt++; if (addr !== exp || stack_ovf !== 1'b0) $display("FAIL callwrap_ret addr=%0d ovf=%b exp %0d/0", addr, stack_ovf, exp); else pass_cnt++;
    endtask

    task automatic test_stack_ovf();
        logic [5:0] ret_exp [5];
        logic [5:0] call_t  [4];
        call_t = '{6'd30, 6'd40, 6'd50, 6'd60};
        if (STK) ret_exp = '{6'd51, 6'd41, 6'd31, 6'd11, 6'd12};
        else     ret_exp = '{6'd3, 6'd4, 6'd5, 6'd6, 6'd7};
        do_reset();
        op(OP_JUMP, 6'd10);
        for (int i = 0; i < 4; i++) begin
            op(OP_CALL, call_t[i]);
            chk_cnt++; if (addr !== call_t[i]) $display("FAIL nest_call%0d got=%0d exp=%0d", i, addr, call_t[i]); else pass_cnt++;
        end
        chk_cnt++; if (stack_ovf !== 1'b0) $display("FAIL nest_no_ovf got=%b exp=0", stack_ovf); else pass_cnt++;
        op(OP_CALL, 6'd2);
        chk_cnt++; if (addr !== 6'd2) $display("FAIL ovf_jump got=%0d exp=2", addr); else pass_cnt++;
        chk_cnt++; if (stack_ovf !== STK) $display("FAIL ovf_flag got=%b exp=%b", stack_ovf, STK); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            op(OP_RET, 6'd0);
            chk_cnt++; if (addr !== ret_exp[i]) $display("FAIL unwind%0d got=%0d exp=%0d", i, addr, ret_exp[i]); else pass_cnt++;
        end
        chk_cnt++; if (stack_unf !== STK) $display("FAIL unf_flag got=%b exp=%b", stack_unf, STK); else pass_cnt++;
        chk_cnt++; if (stack_ovf !== STK) $display("FAIL ovf_sticky got=%b exp=%b", stack_ovf, STK); else pass_cnt++;
        // Asynchronous reset mid-cycle clears the sticky flags without a clock edge.
        @(negedge clk);
        #2;
        res = 1'b0;
        #1;
        chk_cnt++; if (stack_ovf !== 1'b0 || stack_unf !== 1'b0 || addr !== 6'd0) $display("FAIL async_rst ovf=%b unf=%b addr=%0d exp 0/0/0", stack_ovf, stack_unf, addr); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic exp_unf;
        do_reset();
        op(OP_JUMP, 6'd12);
        stall = 1'b1;
        op(OP_JUMP, 6'd9);
        chk_cnt++; if (addr !== 6'd12) $display("FAIL stall_addr got=%0d exp=12", addr); else pass_cnt++;
        chk_cnt++; if (instr_valid !== 1'b0) $display("FAIL stall_valid got=%b exp=0", instr_valid); else pass_cnt++;
        op(OP_HALT, 6'd0);
        chk_cnt++; if (halted !== 1'b0 || addr !== 6'd12) $display("FAIL stall_halt halted=%b addr=%0d exp 0/12", halted, addr); else pass_cnt++;
        // A stalled CALL must not push, so the following RET underflows.
        op(OP_CALL, 6'd40);
        chk_cnt++; if (addr !== 6'd12) $display("FAIL stall_call got=%0d exp=12", addr); else pass_cnt++;
        stall = 1'b0;
        op(OP_RET, 6'd0);
        exp_unf = STK;
        chk_cnt++; if (addr !== 6'd13 || stack_unf !== exp_unf) $display("FAIL stall_ret addr=%0d unf=%b exp 13/%b", addr, stack_unf, exp_unf); else pass_cnt++;
        chk_cnt++; if (instr_valid !== 1'b1) $display("FAIL unstall_valid got=%b exp=1", instr_valid); else pass_cnt++;
    endtask

    task automatic test_halt();
        do_reset();
        op(OP_JUMP, 6'd33);
        op(OP_HALT, 6'd0);
        chk_cnt++; if (halted !== 1'b1 || addr !== 6'd33) $display("FAIL halt_enter halted=%b addr=%0d exp 1/33", halted, addr); else pass_cnt++;
        op(OP_INC, 6'd0);
        chk_cnt++; if (addr !== 6'd33 || halted !== 1'b1 || instr_valid !== 1'b0) $display("FAIL halt_frozen addr=%0d halted=%b valid=%b exp 33/1/0", addr, halted, instr_valid); else pass_cnt++;
        op(OP_JUMP, 6'd1);
        chk_cnt++; if (addr !== 6'd33) $display("FAIL halt_jump got=%0d exp=33", addr); else pass_cnt++;
        @(negedge clk);
        res = 1'b0;
        #1;
        chk_cnt++; if (addr !== 6'd0 || halted !== 1'b0 || instr_valid !== 1'b0) $display("FAIL halt_rst addr=%0d halted=%b valid=%b exp 0/0/0", addr, halted, instr_valid); else pass_cnt++;
        pc_op = OP_INC;
        @(negedge clk);
        res = 1'b1;
        tick();
        chk_cnt++; if (addr !== 6'd0 || halted !== 1'b0) $display("FAIL halt_boot addr=%0d halted=%b exp 0/0", addr, halted); else pass_cnt++;
        tick();
        chk_cnt++; if (addr !== 6'd1) $display("FAIL halt_resume got=%0d exp=1", addr); else pass_cnt++;
    endtask

    task automatic test_reset_mid_call();
        do_reset();
        op(OP_JUMP, 6'd4);
        pc_op  = OP_CALL;
        target = 6'd30;
        @(negedge clk);
        res = 1'b0;
        #1;
        chk_cnt++; if (addr !== 6'd0) $display("FAIL midcall_rst got=%0d exp=0", addr); else pass_cnt++;
        pc_op = OP_RET;
        @(negedge clk);
        res = 1'b1;
        tick();
        tick();
        chk_cnt++; if (addr !== 6'd1 || stack_unf !== STK) $display("FAIL midcall_ret addr=%0d unf=%b exp 1/%b", addr, stack_unf, STK); else pass_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        res      = 1'b0;
        pc_op    = OP_INC;
        target   = 6'd0;
        stall    = 1'b0;
        instr_in = 9'd0;
        test_reset();
        test_boot_inc();
        test_wrap();
        test_passthrough();
        test_call_ret();
        test_stack_ovf();
        test_stall();
        test_halt();
        test_reset_mid_call();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6, instruction address width in bits.
REQ-002 Parameter INSTR_W, default 9, instruction word width in bits.
REQ-003 Parameter STACK_DEPTH, default 4, return-stack entries (>=2).
REQ-004 Parameter RESET_ADDR, default 0, first fetch address after reset.
REQ-005 The block SHALL use a single clock: clk  in  1  clock, rising edge.
REQ-006 res  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-007 pc_op  in  3  next-address operation: 000 HOLD, 001 INC, 010 JUMP, 011 CALL, 100 RET, 101 HALT, others = HOLD.
REQ-008 target  in  ADDR_W  destination address for JUMP/CALL.
REQ-009 stall  in  1  forces HOLD, overriding pc_op.
REQ-010 addr  out  ADDR_W  registered fetch address to the synchronous instruction memory.
REQ-011 instr_in  in  INSTR_W  memory read data (one-cycle read latency).
REQ-012 instr_out  out  INSTR_W  combinational copy of instr_in.
REQ-013 instr_valid  out  1  instr_out holds a freshly fetched instruction this cycle.
REQ-014 halted  out  1  sequencer is in HALT.
REQ-015 stack_ovf  out  1  sticky: CALL attempted with full stack.
REQ-016 stack_unf  out  1  sticky: RET attempted with empty stack.

Function
REQ-017 States SHALL be BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-018 In BOOT, addr SHALL hold RESET_ADDR and instr_valid SHALL be 0.
REQ-019 In RUN, on each edge: HOLD keeps addr; INC sets addr+1 mod 2^ADDR_W; JUMP sets target; CALL pushes addr+1 (wrapped) and sets target; RET pops top into addr.
REQ-020 HALT op in RUN SHALL freeze addr, enter HALT and assert halted next cycle; only reset leaves HALT.
REQ-021 instr_valid SHALL be 1 in cycle t+1 iff state was RUN and stall was 0 in cycle t.
REQ-022 INC/CALL at addr = 2^ADDR_W-1 SHALL wrap to 0 with no flag.
REQ-023 CALL with STACK_DEPTH entries SHALL still jump, drop the push, set stack_ovf.
REQ-024 RET with empty stack SHALL behave as INC and set stack_unf.
REQ-025 stall=1 SHALL leave addr, stack and flags unchanged regardless of pc_op.

Reset
REQ-026 res=0 SHALL asynchronously force addr=RESET_ADDR, state BOOT, stack empty, instr_valid=0, halted=0, stack_ovf=0, stack_unf=0.
REQ-027 Reset asserted mid-CALL/RET or in HALT SHALL discard all pending state; no partial stack update survives.

Configuration
REQ-028 Macro FETCH_SEQ_STACK_EN compiled in: return stack and REQ-019 CALL/RET, REQ-023, REQ-024 behaviour present.
REQ-029 Without FETCH_SEQ_STACK_EN: no stack storage; CALL SHALL act as JUMP, RET as INC; stack_ovf and stack_unf tied 0.

Structure
REQ-030 Shared package fetch_seq_pkg SHALL hold the pc_op encodings and the state encoding.
REQ-031 The return stack SHALL be sub-module fetch_ret_stack (push, pop, top, full, empty), instantiated only under FETCH_SEQ_STACK_EN.

Verification
REQ-032 Reset release, pc_op=INC -> addr 0 for two cycles (BOOT), then 1,2,3; instr_valid first 1 in cycle after first increment edge.
REQ-033 addr=63 (ADDR_W=6), INC -> addr=0, no flag.
REQ-034 addr=5, CALL target=20 -> addr=20; later RET -> addr=6.
REQ-035 Five nested CALLs (depth 4) -> fifth jumps, stack_ovf=1; RET on empty stack -> addr+1, stack_unf=1.
REQ-036 stall=1 with pc_op=JUMP target=9 -> addr unchanged, instr_valid=0 next cycle; HALT -> halted=1, addr frozen until res=0 pulse restores addr=0.
